uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx serializer between NUM_REQ byte producers using round-robin arbitration.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and uart_tx-side signals of the shared serializer arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned TX_DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*TX_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]               req_ack;
    logic [NUM_REQ-1:0]               req_done;
    logic [TX_DATA_WIDTH-1:0]         uart_tx_data;
    logic                             uart_tx_data_req;
    logic                             uart_tx_busy;
    logic                             uart_tx_done;

    // Arbiter side: owns all uart_tx input pins and the ack/done pulses.
    modport master (
        input  req_valid, req_data, uart_tx_busy, uart_tx_done,
        output req_ack, req_done, uart_tx_data, uart_tx_data_req
    );

    // Producers plus uart_tx instance.
    modport slave (
        output req_valid, req_data, uart_tx_busy, uart_tx_done,
        input  req_ack, req_done, uart_tx_data, uart_tx_data_req
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte producers.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned TX_DATA_WIDTH = 8,
    parameter int unsigned BUSY_TIMEOUT  = 8,
    localparam int unsigned ID_W         = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                sysclk,
    input  logic                rstn,
    uart_tx_arbiter_if.master   bus,
    output logic [ID_W-1:0]     grant_id,
    output logic                arb_busy,
    output logic                arb_err
);

    localparam int unsigned CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t                   state;
    logic [ID_W-1:0]          rr_ptr;
    logic [CNT_W-1:0]         busy_cnt;
    logic [ID_W-1:0]          scan_id;
    logic [ID_W-1:0]          win_id;
    logic                     win_found;
    logic [ID_W-1:0]          next_ptr;
    logic [TX_DATA_WIDTH-1:0] win_data;
    logic [TX_DATA_WIDTH-1:0] data_arr [NUM_REQ];

    // Unpack the flat producer data bus into one byte per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = bus.req_data[g*TX_DATA_WIDTH +: TX_DATA_WIDTH];
    end

    // Winner: first valid requester scanning upward from rr_ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr;
        scan_id   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_id = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && bus.req_valid[scan_id]) begin
                win_found = 1'b1;
                win_id    = scan_id;
            end
        end
    end

    // Winner's byte and the pointer value just past the winner.
    always_comb begin
        win_data = data_arr[win_id];
        next_ptr = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(win_id + 1'b1);
    end

    // Arbitration FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state                <= ST_IDLE;
            rr_ptr               <= '0;
            busy_cnt             <= '0;
            grant_id             <= '0;
            arb_busy             <= 1'b0;
            arb_err              <= 1'b0;
            bus.req_ack          <= '0;
            bus.req_done         <= '0;
            bus.uart_tx_data     <= '0;
            bus.uart_tx_data_req <= 1'b0;
        end else begin
            bus.req_ack          <= '0;
            bus.req_done         <= '0;
            bus.uart_tx_data_req <= 1'b0;
            arb_err              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        bus.uart_tx_data     <= win_data;
                        bus.uart_tx_data_req <= 1'b1;
                        bus.req_ack          <= NUM_REQ'(1) << win_id;
                        grant_id             <= win_id;
                        rr_ptr               <= next_ptr;
                        busy_cnt             <= '0;
                        arb_busy             <= 1'b1;
                        state                <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    // Busy wins over the timeout on the final counted cycle.
                    if (bus.uart_tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        arb_err  <= 1'b1;
                        arb_busy <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        busy_cnt <= CNT_W'(busy_cnt + 1'b1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.uart_tx_done) begin
                        bus.req_done <= NUM_REQ'(1) << grant_id;
                        arb_busy     <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    arb_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a transaction-level reference.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned W       = 8;
    localparam int unsigned BT      = 8;

    logic       sysclk = 1'b0;
    logic       rstn;
    logic [1:0] grant_id;
    logic       arb_busy;
    logic       arb_err;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .TX_DATA_WIDTH(W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .TX_DATA_WIDTH(W),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .sysclk  (sysclk),
        .rstn    (rstn),
        .bus     (bus.master),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .arb_err (arb_err)
    );

    always #5 sysclk = ~sysclk;

    // One comparison: count it, report it if it differs.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round-robin reference: first set bit from ptr upward, wrapping.
    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            int idx;
            idx = (ptr + i) % int'(NUM_REQ);
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // All pulse outputs gathered; must be zero whenever nothing is expected.
    function automatic logic [31:0] pulses();
        return 32'({bus.uart_tx_data_req, bus.req_ack, bus.req_done, arb_err});
    endfunction

    // Idle cycles with no requests; a stray uart_tx_done must be ignored.
    task automatic idle_gap(input int n);
        bus.req_valid = '0;
        for (int i = 0; i < n; i++) begin
            bus.uart_tx_done = (i == 0);
            @(negedge sysclk);
            bus.uart_tx_done = 1'b0;
            check_val("idle_pulses", pulses(), 32'd0);
            check_val("idle_busy", 32'(arb_busy), 32'd0);
        end
    endtask

    // One frame, entered at a negedge where the arbiter is idle.
    task automatic run_frame(input logic [3:0] valid, input logic [31:0] data, input bit timeout,
                             input int dly, input int hold, input bit keep, input logic [3:0] gmask);
        int         w;
        logic [7:0] exp_byte;
        bus.req_valid = valid;
        bus.req_data  = data;
        w        = rr_pick(valid, m_ptr);
        exp_byte = 8'(data >> (w * 8));
        @(negedge sysclk);
        check_val("data_req", 32'(bus.uart_tx_data_req), 32'd1);
        check_val("ack", 32'(bus.req_ack), 32'd1 << w);
        check_val("tx_data", 32'(bus.uart_tx_data), 32'(exp_byte));
        check_val("grant_id", 32'(grant_id), 32'(w));
        check_val("arb_busy_grant", 32'(arb_busy), 32'd1);
        m_ptr = (w + 1) % int'(NUM_REQ);
        if (!keep) bus.req_valid = '0;
        bus.req_data = $urandom;
        if (timeout) begin
            for (int c = 1; c < int'(BT); c++) begin
                bus.uart_tx_done = (c == 2);
                @(negedge sysclk);
                check_val("tmo_wait_pulses", pulses(), 32'd0);
                check_val("tmo_wait_busy", 32'(arb_busy), 32'd1);
            end
            bus.uart_tx_done = 1'b0;
            @(negedge sysclk);
            check_val("arb_err", 32'(arb_err), 32'd1);
            check_val("tmo_busy_clear", 32'(arb_busy), 32'd0);
            check_val("tmo_no_done", 32'(bus.req_done), 32'd0);
        end else begin
            for (int c = 0; c < dly; c++) begin
                bus.uart_tx_done = (c == 0);
                @(negedge sysclk);
                bus.uart_tx_done = 1'b0;
                check_val("wb_pulses", pulses(), 32'd0);
                check_val("wb_busy", 32'(arb_busy), 32'd1);
            end
            bus.uart_tx_busy = 1'b1;
            for (int h = 0; h < hold; h++) begin
                if (gmask != 4'd0 && !keep) bus.req_valid = (h == 0) ? gmask : 4'd0;
                @(negedge sysclk);
                check_val("wd_pulses", pulses(), 32'd0);
                check_val("wd_busy", 32'(arb_busy), 32'd1);
            end
            bus.uart_tx_done = 1'b1;
            bus.uart_tx_busy = 1'b0;
            @(negedge sysclk);
            bus.uart_tx_done = 1'b0;
            check_val("req_done", 32'(bus.req_done), 32'd1 << w);
            check_val("done_busy_clear", 32'(arb_busy), 32'd0);
            check_val("done_grant_id", 32'(grant_id), 32'(w));
            check_val("done_no_err", 32'(arb_err), 32'd0);
        end
    endtask

    // Reset in the middle of a frame, then release at a negedge.
    task automatic reset_mid_frame();
        bus.req_valid = 4'b1000;
        @(negedge sysclk);
        check_val("rst_pre_data_req", 32'(bus.uart_tx_data_req), 32'd1);
        bus.req_valid    = '0;
        bus.uart_tx_busy = 1'b1;
        repeat (3) @(negedge sysclk);
        rstn = 1'b0;
        #1;
        check_val("rst_ack", 32'(bus.req_ack), 32'd0);
        check_val("rst_done", 32'(bus.req_done), 32'd0);
        check_val("rst_tx_data", 32'(bus.uart_tx_data), 32'd0);
        check_val("rst_data_req", 32'(bus.uart_tx_data_req), 32'd0);
        check_val("rst_grant_id", 32'(grant_id), 32'd0);
        check_val("rst_arb_busy", 32'(arb_busy), 32'd0);
        check_val("rst_arb_err", 32'(arb_err), 32'd0);
        bus.uart_tx_busy = 1'b0;
        m_ptr = 0;
        @(negedge sysclk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] gm;
        bit         to;
        bit         keep;
        rstn             = 1'b0;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.uart_tx_busy = 1'b0;
        bus.uart_tx_done = 1'b0;
        repeat (3) @(negedge sysclk);
        check_val("init_pulses", pulses(), 32'd0);
        check_val("init_tx_data", 32'(bus.uart_tx_data), 32'd0);
        check_val("init_grant_id", 32'(grant_id), 32'd0);
        check_val("init_arb_busy", 32'(arb_busy), 32'd0);
        rstn = 1'b1;

        // Single requester 2 with 0xA5; busy rises on the last allowed cycle.
        run_frame(4'b0100, 32'h00A5_0000, 1'b0, int'(BT) - 1, 9, 1'b0, 4'd0);
        // Pointer at 3 wraps to requester 0, then 1.
        run_frame(4'b0011, $urandom, 1'b0, 1, 3, 1'b1, 4'd0);
        run_frame(4'b0011, $urandom, 1'b0, 0, 2, 1'b0, 4'd0);
        // uart_tx never goes busy.
        run_frame(4'b1111, $urandom, 1'b1, 0, 0, 1'b0, 4'd0);
        idle_gap(2);
        // Requester 1 pulses only while requester 0's frame is in flight.
        run_frame(4'b0001, $urandom, 1'b0, 1, 4, 1'b0, 4'b0010);
        idle_gap(4);
        // Mid-frame reset, then all four continuously valid in order 10..13,10.
        reset_mid_frame();
        for (int i = 0; i < 5; i++) begin
            run_frame(4'b1111, 32'h1312_1110, 1'b0, 1, 3, 1'b1, 4'd0);
        end
        idle_gap(2);

        for (int i = 0; i < 80; i++) begin
            v    = 4'($urandom_range(1, 15));
            to   = ($urandom_range(0, 5) == 0);
            keep = 1'($urandom_range(0, 1));
            gm   = (!keep && $urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            run_frame(v, $urandom, to, int'($urandom_range(0, BT - 1)),
                      int'($urandom_range(2, 6)), keep, gm);
            if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
